// File: rtl/mips_alu_seq_if.sv
// mips_alu_seq_if -- request/response bundle for the sequential MIPS ALU.
//   master: requester side. It drives in_valid, ALUOp, FuncCode, a, b and shamt,
//           and it observes in_ready and the registered results.
//   slave : ALU side (mips_alu_seq). It takes the requests and drives in_ready,
//           out_valid, result, zero, ovf, err, hi and lo.
interface mips_alu_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       ALUOp;
    logic [5:0]       FuncCode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             err;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, ALUOp, FuncCode, a, b, shamt,
        input  in_ready, out_valid, result, zero, ovf, err, hi, lo
    );

    modport slave (
        input  in_valid, ALUOp, FuncCode, a, b, shamt,
        output in_ready, out_valid, result, zero, ovf, err, hi, lo
    );
endinterface

// File: rtl/mips_alu_seq.sv
// mips_alu_seq -- MIPS ALU. Single-cycle ops finish in one cycle. Multiply and
// divide run as multi-cycle operations that write into the hi/lo registers.
//   clk   : single clock. All state changes on the rising edge.
//   rst_n : asynchronous reset, active low.
//   bus   : mips_alu_seq_if.slave
//     in_valid/in_ready : a request is accepted when both are high. in_ready is
//                         high only in IDLE.
//     ALUOp, FuncCode   : operation select. ALUOp 0 = add, 1 = sub,
//                         2 = R-type (decode FuncCode), 3 = illegal.
//     a, b, shamt       : operands. a = rs, b = rt.
//     out_valid         : one-cycle completion pulse.
//     result, zero, ovf, err : registered result and flags.
//     hi, lo            : multiply/divide result registers.
module mips_alu_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_alu_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mcand_q;
    logic             is_div_q, div0_q, neg_lo_q, neg_hi_q;
    logic [WIDTH-1:0] result_q, hi_q, lo_q;
    logic             out_valid_q, zero_q, ovf_q, err_q;

    logic             accept, last;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum, dif, mag_a, mag_b, op_res;
    logic             ovf_add, ovf_sub;
    logic             op_ovf, op_err, op_mul, op_div, op_sgn;

    // Iteration datapath
    logic [WIDTH:0]     mul_sum, div_t;
    logic [WIDTH-1:0]   div_dif;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign sh      = bus.shamt;
    assign accept  = bus.in_valid && (state_q == IDLE);
    assign last    = (cnt_q == CW'(WIDTH - 1));
    assign sum     = bus.a + bus.b;
    assign dif     = bus.a - bus.b;
    assign ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
    assign mag_a   = (op_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b   = (op_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Shift-add step. If the low multiplier bit is set, add the multiplicand
    // into the upper half. Then shift the whole product right by one bit.
    assign mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mcand_q} : '0);
    // Restoring-division step. The partial remainder is always below the
    // divisor, so the difference fits in WIDTH bits whenever the trial succeeds.
    assign div_t    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_ge   = (div_t >= {1'b0, mcand_q});
    assign div_dif  = div_t[WIDTH-1:0] - mcand_q;
    assign prod     = {acc_hi_q, acc_lo_q};
    assign prod_neg = -prod;

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        op_err = 1'b0;
        op_mul = 1'b0;
        op_div = 1'b0;
        op_sgn = 1'b0;
        unique case (bus.ALUOp)
            2'd0: op_res = sum;
            2'd1: op_res = dif;
            2'd2: begin
                case (bus.FuncCode)
                    6'd32: begin op_res = sum; op_ovf = ovf_add; end
                    6'd33: op_res = sum;
                    6'd34: begin op_res = dif; op_ovf = ovf_sub; end
                    6'd35: op_res = dif;
                    6'd36: op_res = bus.a & bus.b;
                    6'd37: op_res = bus.a | bus.b;
                    6'd38: op_res = bus.a ^ bus.b;
                    6'd39: op_res = ~(bus.a | bus.b);
                    6'd42: op_res = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
                    6'd43: op_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
                    6'd0:  op_res = bus.b << sh;
                    6'd2:  op_res = bus.b >> sh;
                    6'd3:  op_res = $signed(bus.b) >>> sh;
                    6'd16: op_res = hi_q;
                    6'd18: op_res = lo_q;
                    6'd24: begin op_mul = 1'b1; op_sgn = 1'b1; end
                    6'd25: op_mul = 1'b1;
                    6'd26: begin op_div = 1'b1; op_sgn = 1'b1; end
                    6'd27: op_div = 1'b1;
                    default: op_err = 1'b1;
                endcase
            end
            default: op_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && op_mul) state_d = MUL;
                else if (accept && op_div) state_d = (bus.b == '0) ? FIX : DIV;
            end
            MUL, DIV: if (last) state_d = FIX;
            FIX: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            mcand_q     <= '0;
            is_div_q    <= 1'b0;
            div0_q      <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            result_q    <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            out_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (op_mul || op_div) begin
                            // Run on magnitudes. Record the result signs for FIX.
                            // On divide by zero, acc_hi carries a through to hi.
                            mcand_q  <= op_mul ? mag_a : mag_b;
                            acc_lo_q <= op_mul ? mag_b : mag_a;
                            acc_hi_q <= (op_div && bus.b == '0) ? bus.a : '0;
                            is_div_q <= op_div;
                            div0_q   <= op_div && (bus.b == '0);
                            neg_lo_q <= op_sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            neg_hi_q <= op_sgn && bus.a[WIDTH-1];
                            cnt_q    <= '0;
                        end else begin
                            result_q    <= op_res;
                            zero_q      <= (op_res == '0);
                            ovf_q       <= op_ovf;
                            err_q       <= op_err;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                DIV: begin
                    acc_hi_q <= div_ge ? div_dif : div_t[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                    cnt_q    <= cnt_q + 1'b1;
                end
                FIX: begin
                    if (div0_q) begin
                        hi_q <= acc_hi_q;
                        lo_q <= '1;
                    end else if (is_div_q) begin
                        hi_q <= neg_hi_q ? -acc_hi_q : acc_hi_q;
                        lo_q <= neg_lo_q ? -acc_lo_q : acc_lo_q;
                    end else begin
                        {hi_q, lo_q} <= neg_lo_q ? prod_neg : prod;
                    end
                    result_q    <= '0;
                    zero_q      <= 1'b1;
                    ovf_q       <= 1'b0;
                    err_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_mips_alu_seq.sv
// tb_mips_alu_seq -- self-checking bench for mips_alu_seq with WIDTH = 32.
// The bench uses randomized operands. A behavioural model written with 64-bit
// integer arithmetic produces the expected values.
module tb_mips_alu_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_alu_seq_if #(.WIDTH(W), .SHW(5)) bus();
    mips_alu_seq #(.WIDTH(W), .SHW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h7FFFFFFF;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    // kind: 0 = completes at the accept edge, 1 = full mult/div, 2 = divide by zero
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh, output int kind,
                         output logic [31:0] r, output logic o, output logic e,
                         output logic [31:0] nh, output logic [31:0] nl);
        longint s;
        longint unsigned u;
        kind = 0; r = '0; o = 1'b0; e = 1'b0; nh = m_hi; nl = m_lo;
        if (op == 2'd0) r = av + bv;
        else if (op == 2'd1) r = av - bv;
        else if (op == 2'd3) e = 1'b1;
        else begin
            case (fn)
                6'd32: begin
                    s = longint'($signed(av)) + longint'($signed(bv));
                    r = s[31:0];
                    o = (s != longint'($signed(r)));
                end
                6'd33: r = av + bv;
                6'd34: begin
                    s = longint'($signed(av)) - longint'($signed(bv));
                    r = s[31:0];
                    o = (s != longint'($signed(r)));
                end
                6'd35: r = av - bv;
                6'd36: r = av & bv;
                6'd37: r = av | bv;
                6'd38: r = av ^ bv;
                6'd39: r = ~(av | bv);
                6'd42: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
                6'd43: r = (av < bv) ? 32'd1 : 32'd0;
                6'd0:  r = bv << sh;
                6'd2:  r = bv >> sh;
                6'd3:  r = (bv >> sh) | (bv[31] ? ~(32'hFFFFFFFF >> sh) : 32'h0);
                6'd16: r = m_hi;
                6'd18: r = m_lo;
                6'd24: begin
                    kind = 1;
                    s = longint'($signed(av)) * longint'($signed(bv));
                    {nh, nl} = s;
                end
                6'd25: begin
                    kind = 1;
                    u = 64'(av) * 64'(bv);
                    {nh, nl} = u;
                end
                6'd26, 6'd27: begin
                    if (bv == 32'h0) begin
                        kind = 2; nh = av; nl = 32'hFFFFFFFF;
                    end else if (fn == 6'd26) begin
                        kind = 1;
                        s = longint'($signed(av)) / longint'($signed(bv));
                        nl = s[31:0];
                        s = longint'($signed(av)) % longint'($signed(bv));
                        nh = s[31:0];
                    end else begin
                        kind = 1; nl = av / bv; nh = av % bv;
                    end
                end
                default: e = 1'b1;
            endcase
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] av,
                         input logic [31:0] bv, input logic [4:0] sh);
        @(negedge clk);
        bus.ALUOp = op; bus.FuncCode = fn; bus.a = av; bus.b = bv; bus.shamt = sh;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.ALUOp = '0; bus.FuncCode = '0;
        bus.a = '0; bus.b = '0; bus.shamt = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got v=%b r=%h z=%b o=%b e=%b want v=0 r=0 z=1 o=0 e=0",
                     bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err);
        end
        total++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            bad++; $display("FAIL reset_hilo got %h want 0", {bus.hi, bus.lo});
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [5:0]  fv [4];
        logic [31:0] rv [4];
        logic        ov [4];
        av = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000};
        bv = '{32'h1, 32'h1, 32'h1, 32'h1};
        fv = '{6'd32, 6'd33, 6'd34, 6'd35};
        rv = '{32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'h7FFFFFFF};
        ov = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(2'd2, fv[i], av[i], bv[i], 5'd0);
            total++;
            if ({bus.out_valid, bus.result, bus.ovf, bus.err} !== {1'b1, rv[i], ov[i], 1'b0}) begin
                bad++;
                $display("FAIL ovf_case%0d got v=%b r=%h o=%b e=%b want v=1 r=%h o=%b e=0",
                         i, bus.out_valid, bus.result, bus.ovf, bus.err, rv[i], ov[i]);
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL ovf_pulse%0d got out_valid=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_single_random(input int n);
        logic [5:0] fns [15];
        logic [1:0] op;
        logic [5:0] fn;
        logic [31:0] av, bv, r, nh, nl;
        logic [4:0] sh;
        logic o, e;
        int kind, sel;
        fns = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39,
                6'd42, 6'd43, 6'd0, 6'd2, 6'd3, 6'd16, 6'd18};
        for (int i = 0; i < n; i++) begin
            sel = int'($urandom_range(0, 14));
            fn = fns[sel];
            op = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(0, 1)) : 2'd2;
            av = rnd_val(); bv = rnd_val(); sh = 5'($urandom);
            model(op, fn, av, bv, sh, kind, r, o, e, nh, nl);
            drive(op, fn, av, bv, sh);
            total++;
            if ({bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err} !== {1'b1, r, r == 32'h0, o, e}) begin
                bad++;
                $display("FAIL single op=%0d fn=%0d a=%h b=%h sh=%0d got v=%b r=%h z=%b o=%b e=%b want r=%h o=%b e=%b",
                         op, fn, av, bv, sh, bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err, r, o, e);
            end
            total++;
            if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin
                bad++; $display("FAIL single_hilo got %h want %h", {bus.hi, bus.lo}, {m_hi, m_lo});
            end
            @(posedge clk); #1;
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++; $display("FAIL single_pulse got out_valid=%b want 0", bus.out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [5:0] fn;
        logic [31:0] av, bv, r, nh, nl;
        logic o, e;
        int kind;
        for (int i = 0; i < 8; i++) begin
            op = 2'd2;
            fn = (i % 2 == 0) ? 6'd32 : 6'd38;
            av = $urandom; bv = $urandom;
            model(op, fn, av, bv, 5'd0, kind, r, o, e, nh, nl);
            @(negedge clk);
            bus.ALUOp = op; bus.FuncCode = fn; bus.a = av; bus.b = bv; bus.shamt = '0;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if ({bus.in_ready, bus.out_valid, bus.result, bus.ovf} !== {1'b1, 1'b1, r, o}) begin
                bad++;
                $display("FAIL b2b%0d got rdy=%b v=%b r=%h o=%b want rdy=1 v=1 r=%h o=%b",
                         i, bus.in_ready, bus.out_valid, bus.result, bus.ovf, r, o);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_long_op(input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] r, nh, nl;
        logic o, e;
        int kind, cyc, lat;
        model(2'd2, fn, av, bv, 5'd0, kind, r, o, e, nh, nl);
        drive(2'd2, fn, av, bv, 5'd0);
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            total++;
            if (bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL busy_ready fn=%0d cyc=%0d got %b want 0", fn, cyc, bus.in_ready);
            end
            // Garbage requests and operand changes must not disturb the running op.
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.ALUOp = 2'd2; bus.FuncCode = 6'd32;
            bus.a = $urandom; bus.b = $urandom;
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid = 1'b0;
        m_hi = nh; m_lo = nl;
        lat = (kind == 2) ? 1 : 33;
        total++;
        if (cyc != lat) begin
            bad++; $display("FAIL long_latency fn=%0d got %0d want %0d", fn, cyc, lat);
        end
        total++;
        if ({bus.result, bus.zero, bus.ovf, bus.err} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL long_flags fn=%0d got r=%h z=%b o=%b e=%b want r=0 z=1 o=0 e=0",
                     fn, bus.result, bus.zero, bus.ovf, bus.err);
        end
        total++;
        if ({bus.hi, bus.lo} !== {nh, nl}) begin
            bad++;
            $display("FAIL long_hilo fn=%0d a=%h b=%h got %h want %h", fn, av, bv, {bus.hi, bus.lo}, {nh, nl});
        end
        @(posedge clk); #1;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++; $display("FAIL long_after got v=%b rdy=%b want v=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_mult();
        test_long_op(6'd25, 32'hFFFFFFFF, 32'hFFFFFFFF);
        total++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFE_00000001) begin
            bad++; $display("FAIL multu_max got %h want fffffffe00000001", {bus.hi, bus.lo});
        end
        drive(2'd2, 6'd16, 32'h0, 32'h0, 5'd0);
        total++;
        if (bus.result !== 32'hFFFFFFFE) begin
            bad++; $display("FAIL mfhi got %h want fffffffe", bus.result);
        end
        drive(2'd2, 6'd18, 32'h0, 32'h0, 5'd0);
        total++;
        if (bus.result !== 32'h00000001) begin
            bad++; $display("FAIL mflo got %h want 00000001", bus.result);
        end
        test_long_op(6'd24, 32'hFFFFFFFD, 32'h5);
        total++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
            bad++; $display("FAIL mult_neg got %h want fffffffffffffff1", {bus.hi, bus.lo});
        end
        for (int i = 0; i < 6; i++)
            test_long_op((i % 2 == 0) ? 6'd24 : 6'd25, rnd_val(), rnd_val());
    endtask

    task automatic test_div();
        logic [31:0] bv;
        test_long_op(6'd26, 32'hFFFFFFF9, 32'h2);
        total++;
        if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
            bad++; $display("FAIL div_neg got %h want fffffffffffffffd", {bus.hi, bus.lo});
        end
        test_long_op(6'd27, 32'h1234, 32'h0);
        total++;
        if ({bus.hi, bus.lo} !== 64'h00001234_FFFFFFFF) begin
            bad++; $display("FAIL divu_zero got %h want 00001234ffffffff", {bus.hi, bus.lo});
        end
        test_long_op(6'd26, 32'h80000000, 32'hFFFFFFFF);
        test_long_op(6'd26, 32'h5, 32'h0);
        for (int i = 0; i < 6; i++) begin
            bv = rnd_val();
            if (bv == 32'h0) bv = $urandom_range(1, 100);
            test_long_op((i % 2 == 0) ? 6'd26 : 6'd27, rnd_val(), bv);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] ops [5];
        logic [5:0] fns [5];
        ops = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd3};
        fns = '{6'd32, 6'd63, 6'd1, 6'd44, 6'd24};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], fns[i], $urandom, $urandom, 5'($urandom));
            total++;
            if ({bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL illegal%0d got v=%b r=%h z=%b o=%b e=%b want v=1 r=0 z=1 o=0 e=1",
                         i, bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err);
            end
            total++;
            if ({bus.hi, bus.lo} !== {m_hi, m_lo}) begin
                bad++; $display("FAIL illegal_hilo%0d got %h want %h", i, {bus.hi, bus.lo}, {m_hi, m_lo});
            end
            @(posedge clk); #1;
            total++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                bad++; $display("FAIL illegal_pulse%0d got v=%b rdy=%b want v=0 rdy=1", i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] av, bv;
        int highs;
        drive(2'd2, 6'd25, 32'hDEADBEEF, 32'h12345678, 5'd0);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        total++;
        if ({bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err, bus.hi, bus.lo} !==
            {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 64'h0}) begin
            bad++;
            $display("FAIL async_reset got rdy=%b v=%b r=%h z=%b o=%b e=%b hilo=%h want rdy=1 v=0 r=0 z=1 o=0 e=0 hilo=0",
                     bus.in_ready, bus.out_valid, bus.result, bus.zero, bus.ovf, bus.err, {bus.hi, bus.lo});
        end
        @(negedge clk);
        av = $urandom; bv = $urandom;
        rst_n = 1'b1;
        bus.ALUOp = 2'd0; bus.FuncCode = 6'd0; bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.result, bus.ovf, bus.err} !== {1'b1, av + bv, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_add got v=%b r=%h o=%b e=%b want v=1 r=%h o=0 e=0",
                     bus.out_valid, bus.result, bus.ovf, bus.err, av + bv);
        end
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) highs++;
        end
        total++;
        if (highs != 0) begin
            bad++; $display("FAIL abandoned_mult got %0d out_valid pulses want 0", highs);
        end
        total++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            bad++; $display("FAIL abandoned_hilo got %h want 0", {bus.hi, bus.lo});
        end
    endtask

    initial begin
        test_reset();
        test_overflow();
        test_single_random(40);
        test_back_to_back();
        test_mult();
        test_div();
        test_illegal();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mips_alu_seq.md
MIPS_ALU_SEQ -- requirements
Module: mips_alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8..64, even.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  high when a request can be accepted.
REQ-007 SHALL have port ALUOp  input  2  0=add, 1=sub, 2=R-type (decode FuncCode), 3=reserved.
REQ-008 SHALL have port FuncCode  input  6  R-type function field.
REQ-009 SHALL have port a, b  input  WIDTH each  operands (a=rs, b=rt).
REQ-010 SHALL have port shamt  input  SHW  shift amount.
REQ-011 SHALL have port out_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port zero  output  1  registered (result==0).
REQ-014 SHALL have port ovf  output  1  signed overflow, add/sub funct only.
REQ-015 SHALL have port err  output  1  illegal operation.
REQ-016 SHALL have port hi, lo  output  WIDTH each  multiply/divide result registers.

Function
REQ-017 SHALL accept a request at rising edge k when in_valid && in_ready; in_ready = (state==IDLE).
REQ-018 SHALL implement states IDLE, MUL, DIV, FIX; IDLE->MUL on mult/multu, IDLE->DIV on div/divu with b!=0, IDLE->FIX on div/divu with b==0, MUL/DIV->FIX after WIDTH iterations, FIX->IDLE unconditionally.
REQ-019 SHALL decode ALUOp 0 as add (ovf=0) and ALUOp 1 as sub (ovf=0).
REQ-020 SHALL decode FuncCode: 32 add, 33 addu, 34 sub, 35 subu, 36 and, 37 or, 38 xor, 39 nor, 42 slt (signed), 43 sltu, 0 sll b by shamt, 2 srl, 3 sra, 16 mfhi, 18 mflo, 24 mult, 25 multu, 26 div, 27 divu.
REQ-021 SHALL complete single-cycle ops at edge k: result, zero, ovf, err registered, out_valid=1 for the following cycle only.
REQ-022 SHALL set ovf=1 only for funct 32/34 on signed overflow; add/sub wrap modulo 2^WIDTH.
REQ-023 SHALL set slt/sltu result to 1 or 0, zero-extended to WIDTH.
REQ-024 SHALL treat ALUOp 3 or any unlisted FuncCode as illegal: result=0, zero=1, err=1, out_valid pulse at edge k, hi/lo unchanged.
REQ-025 SHALL run multiply as WIDTH shift-add iterations on edges k+1..k+WIDTH, operands converted to magnitude for mult, sign fixed in FIX.
REQ-026 SHALL run divide as WIDTH restoring iterations on edges k+1..k+WIDTH; quotient truncates toward zero, remainder sign follows dividend.
REQ-027 SHALL write hi (upper product / remainder) and lo (lower product / quotient) and pulse out_valid at FIX edge k+WIDTH+1; result=0, zero=1, err=0, ovf=0 on that pulse.
REQ-028 SHALL, for div/divu with b==0, write lo={WIDTH{1}}, hi=a and pulse out_valid at edge k+1; err=0.
REQ-029 SHALL return hi/lo values for mfhi/mflo as of edge k (latest completed mult/div).
REQ-030 SHALL capture operands at accept; input changes during MUL/DIV/FIX SHALL not affect the result.
REQ-031 SHALL ignore in_valid while in_ready=0 (no queuing); out_valid SHALL never be high two consecutive cycles for one request.

Reset
REQ-032 SHALL on rst_n low immediately force state=IDLE, out_valid=0, result=0, zero=1, ovf=0, err=0, hi=0, lo=0, iteration counter=0, regardless of operation in progress.
REQ-033 SHALL abandon an in-flight mult/div on reset with no out_valid pulse; in_ready=1 from the first edge after deassertion.

Verification (WIDTH=32)
REQ-034 ALUOp=2, FuncCode=32, a=0x7FFFFFFF, b=1 -> edge k: result=0x80000000, ovf=1, out_valid one cycle; FuncCode=33 same operands -> ovf=0.
REQ-035 multu a=b=0xFFFFFFFF accepted at edge k -> in_ready=0 edges k..k+32, out_valid only at k+33, hi=0xFFFFFFFE, lo=0x00000001; then mfhi -> result=0xFFFFFFFE.
REQ-036 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at k+33; mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-037 divu a=0x1234, b=0 -> edge k+1: lo=0xFFFFFFFF, hi=0x1234, out_valid=1, err=0.
REQ-038 Assert rst_n low at k+10 of a mult -> outputs at reset values asynchronously, no out_valid; new add accepted at first edge after release completes correctly.
REQ-039 ALUOp=3, and ALUOp=2 with FuncCode=63 -> result=0, zero=1, err=1, out_valid one cycle, hi/lo unchanged.
